// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller and the memory wrapper.
// The address width and depth here must agree with the memory wrapper's geometry.
package imem_load_ctrl_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_HALT
  } imem_ctrl_state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Valid/ready stream carrying one program entry (two data words) per beat.
interface imem_load_ctrl_if #(
  parameter int DATA_W = imem_load_ctrl_pkg::IMEM_DATA_W
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] wr_data2;

  modport master (output wr_valid, output wr_data1, output wr_data2, input wr_ready);
  modport slave  (input wr_valid, input wr_data1, input wr_data2, output wr_ready);
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer: streams a program image into the memory's
// external-load port while holding the core halted, then manages run/halt/reload.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  imem_load_ctrl_if.slave   wr,
  input  logic              halt_req,
  input  logic              resume,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [DATA_W-1:0] InstExMemData1,
  output logic [DATA_W-1:0] InstExMemData2,
  output logic              enable_halt,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int LEN_W = ADDR_W + 1;

  imem_ctrl_state_t state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             wr_ready_q;
  logic             len_valid, beat, last_beat, start_load;
  logic             wr_ready_d, busy_d, enable_halt_d, load_done_d, load_err_d;

  assign wr.wr_ready = wr_ready_q;

  assign len_valid  = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
  assign beat       = wr.wr_valid && wr_ready_q;
  assign last_beat  = beat && (cnt == len_q - LEN_W'(1));
  assign start_load = (state_nxt == ST_LOAD) && (state != ST_LOAD);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (load_start && len_valid) state_nxt = ST_LOAD;
      ST_LOAD:  if (last_beat) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      ST_RUN:   if (halt_req) state_nxt = ST_HALT;
      // A reload request takes priority over a simultaneous resume.
      ST_HALT: begin
        if (load_start && len_valid) state_nxt = ST_LOAD;
        else if (resume)             state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so that the registered versions line up with it.
  always_comb begin
    wr_ready_d    = (state_nxt == ST_LOAD);
    busy_d        = (state_nxt == ST_LOAD) || (state_nxt == ST_FLUSH);
    enable_halt_d = (state_nxt != ST_RUN);
    load_done_d   = last_beat;
    load_err_d    = load_start &&
                    !(((state == ST_IDLE) || (state == ST_HALT)) && len_valid);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_ready_q  <= 1'b0;
      busy        <= 1'b0;
      enable_halt <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ready_q  <= wr_ready_d;
      busy        <= busy_d;
      enable_halt <= enable_halt_d;
      load_done   <= load_done_d;
      load_err    <= load_err_d;
    end
  end

  // NOTE: these port registers are reset so the memory port idles at zero; the memory array itself lives in the wrapper and keeps its contents across reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                <= '0;
      len_q              <= '0;
      enable_load_ex_mem <= 1'b0;
      InstExMemAddress   <= '0;
      InstExMemData1     <= '0;
      InstExMemData2     <= '0;
    end else begin
      enable_load_ex_mem <= beat;
      if (start_load) begin
        cnt   <= '0;
        len_q <= load_len;
      end else if (beat) begin
        InstExMemAddress <= cnt[ADDR_W-1:0];
        InstExMemData1   <= wr.wr_data1;
        InstExMemData2   <= wr.wr_data2;
        cnt              <= cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: expected memory writes are queued as beats are
// driven and matched against each write strobe.
module tb_imem_load_ctrl;
  import imem_load_ctrl_pkg::*;

  localparam int ADDR_W = IMEM_ADDR_W;
  localparam int DATA_W = IMEM_DATA_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } exp_wr_t;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst_n = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              halt_req = 1'b0;
  logic              resume = 1'b0;
  logic              enable_load_ex_mem;
  logic [ADDR_W-1:0] InstExMemAddress;
  logic [DATA_W-1:0] InstExMemData1;
  logic [DATA_W-1:0] InstExMemData2;
  logic              enable_halt;
  logic              load_done;
  logic              load_err;
  logic              busy;

  int      n_checks = 0;
  int      n_fail   = 0;
  exp_wr_t sb[$];
  exp_wr_t mon_e;

  imem_load_ctrl_if #(.DATA_W(DATA_W)) wr_if ();

  imem_load_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load_start         (load_start),
    .load_len           (load_len),
    .wr                 (wr_if),
    .halt_req           (halt_req),
    .resume             (resume),
    .enable_load_ex_mem (enable_load_ex_mem),
    .InstExMemAddress   (InstExMemAddress),
    .InstExMemData1     (InstExMemData1),
    .InstExMemData2     (InstExMemData2),
    .enable_halt        (enable_halt),
    .load_done          (load_done),
    .load_err           (load_err),
    .busy               (busy)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest beat still outstanding.
  always @(negedge clk) begin
    if (rst_n && enable_load_ex_mem) begin
      check("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_w("sb_addr",  64'(InstExMemAddress), 64'(mon_e.addr));
        check_w("sb_data1", 64'(InstExMemData1),   64'(mon_e.d1));
        check_w("sb_data2", 64'(InstExMemData2),   64'(mon_e.d2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_halt"},   enable_halt,        1'b1);
    check({tag, "_strobe"}, enable_load_ex_mem, 1'b0);
    check_w({tag, "_addr"}, 64'(InstExMemAddress), 64'd0);
    check_w({tag, "_d1"},   64'(InstExMemData1),   64'd0);
    check_w({tag, "_d2"},   64'(InstExMemData2),   64'd0);
    check({tag, "_ready"},  wr_if.wr_ready,     1'b0);
    check({tag, "_done"},   load_done,          1'b0);
    check({tag, "_err"},    load_err,           1'b0);
    check({tag, "_busy"},   busy,               1'b0);
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    resume     = 1'b0;
    check("start_ready", wr_if.wr_ready, 1'b1);
    check("start_busy",  busy,           1'b1);
    check("start_halt",  enable_halt,    1'b1);
    check("start_err",   load_err,       1'b0);
  endtask

  task automatic send_beat(input int idx, input logic [DATA_W-1:0] d1,
                           input logic [DATA_W-1:0] d2, input logic last);
    exp_wr_t e;
    e.addr = ADDR_W'(idx);
    e.d1   = d1;
    e.d2   = d2;
    check("beat_ready", wr_if.wr_ready, 1'b1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data1 = d1;
    wr_if.wr_data2 = d2;
    sb.push_back(e);
    tick();
    check("beat_strobe", enable_load_ex_mem, 1'b1);
    check_w("beat_addr", 64'(InstExMemAddress), 64'(idx));
    check("beat_done",  load_done,      last);
    check("beat_ready_after", wr_if.wr_ready, !last);
  endtask

  task automatic finish_to_run();
    wr_if.wr_valid = 1'b0;
    tick();
    check("run_halt",   enable_halt,        1'b0);
    check("run_strobe", enable_load_ex_mem, 1'b0);
    check("run_done",   load_done,          1'b0);
    check("run_busy",   busy,               1'b0);
  endtask

  task automatic expect_err(input logic [ADDR_W:0] len, input logic exp_halt);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    check("err_pulse",  load_err,           1'b1);
    check("err_strobe", enable_load_ex_mem, 1'b0);
    check("err_ready",  wr_if.wr_ready,     1'b0);
    check("err_busy",   busy,               1'b0);
    check("err_halt",   enable_halt,        exp_halt);
    tick();
    check("err_clear",  load_err,           1'b0);
    check("err_ready2", wr_if.wr_ready,     1'b0);
    check("err_halt2",  enable_halt,        exp_halt);
  endtask

  task automatic do_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_enter", enable_halt, 1'b1);
    check("halt_busy",  busy,        1'b0);
    check("halt_ready", wr_if.wr_ready, 1'b0);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data1 = '0;
    wr_if.wr_data2 = '0;

    // Reset with no clock running, then with the clock running.
    #1 rst_n = 1'b0;
    #1 check_reset_outs("rst_noclk");
    clk_en = 1'b1;
    tick();
    tick();
    check_reset_outs("rst_clk");
    rst_n = 1'b1;
    tick();
    check_reset_outs("idle");

    // Out-of-range lengths in IDLE.
    expect_err(10'd0, 1'b1);
    expect_err(10'd513, 1'b1);

    // Four back-to-back entries.
    start_load(10'd4);
    for (int i = 0; i < 4; i++)
      send_beat(i, DATA_W'(32'hA0 + i), DATA_W'(32'hB0 + i), i == 3);
    finish_to_run();

    // load_start while running is rejected.
    expect_err(10'd2, 1'b0);

    // Plain halt then resume.
    do_halt();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_run", enable_halt, 1'b0);

    // Halt, then resume and load together: the load wins.
    do_halt();
    tick();
    check("halt_hold", enable_halt, 1'b1);
    resume = 1'b1;
    start_load(10'd2);
    send_beat(0, DATA_W'(32'hC0), DATA_W'(32'hD0), 1'b0);
    send_beat(1, DATA_W'(32'hC1), DATA_W'(32'hD1), 1'b1);
    finish_to_run();

    // Three entries with a two-cycle wr_valid gap after the first.
    do_halt();
    start_load(10'd3);
    send_beat(0, DATA_W'(32'h1000), DATA_W'(32'h2000), 1'b0);
    wr_if.wr_valid = 1'b0;
    tick();
    check("gap1_strobe", enable_load_ex_mem, 1'b0);
    check("gap1_ready",  wr_if.wr_ready,     1'b1);
    tick();
    check("gap2_strobe", enable_load_ex_mem, 1'b0);
    check("gap2_ready",  wr_if.wr_ready,     1'b1);
    send_beat(1, DATA_W'(32'h1001), DATA_W'(32'h2001), 1'b0);
    send_beat(2, DATA_W'(32'h1002), DATA_W'(32'h2002), 1'b1);
    finish_to_run();

    // Reset after two of five beats, then a fresh single-entry load.
    do_halt();
    start_load(10'd5);
    send_beat(0, DATA_W'(32'h5A0), DATA_W'(32'h5B0), 1'b0);
    send_beat(1, DATA_W'(32'h5A1), DATA_W'(32'h5B1), 1'b0);
    wr_if.wr_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1 check_reset_outs("rst_midload");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outs("post_rst");
    start_load(10'd1);
    send_beat(0, DATA_W'(32'h7777), DATA_W'(32'h8888), 1'b1);
    finish_to_run();

    tick();
    check_w("sb_empty_at_end", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
